// File: rtl/neuron_pkg.sv
// Shared control codes, FSM encoding and saturating arithmetic
// for the LIF neuron tile.
package neuron_pkg;

  localparam logic [3:0] CTRL_RESET    = 4'b0001;
  localparam logic [3:0] CTRL_SETUP    = 4'b0010;
  localparam logic [3:0] CTRL_DATA     = 4'b0110;
  localparam logic [3:0] CTRL_STOP     = 4'b0000;
  localparam logic [3:0] CTRL_FINISHED = 4'b1000;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_ACCUM = 3'd2,
    ST_PAUSE = 3'd3,
    ST_FIRE  = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

  // Operands are pre-extended to 32 bits, so the raw sum never
  // wraps; the result is clamped to a w-bit signed range.
  function automatic logic signed [31:0] sat_add(
    input logic signed [31:0] a,
    input logic signed [31:0] b,
    input int                 w
  );
    logic signed [31:0] s;
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    s  = a + b;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (w - 1));
    if (s > hi) begin
      sat_add = hi;
    end else if (s < lo) begin
      sat_add = lo;
    end else begin
      sat_add = s;
    end
  endfunction

endpackage

// File: rtl/neuron_lif_unit.sv
// One leaky integrate-and-fire neuron: membrane register,
// accumulate, leak, threshold compare and refractory counter.
module neuron_lif_unit
  import neuron_pkg::*;
#(
  parameter int SIZE_DATA  = 8,
  parameter int SIZE_VMEM  = 16,
  parameter int REFRACTORY = 2,
  parameter int RESET_MODE = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr_i,
  input  logic                 load_i,
  input  logic                 acc_i,
  input  logic                 fire_i,
  input  logic [SIZE_VMEM-1:0] vmem_init_i,
  input  logic [SIZE_DATA-1:0] weight_i,
  input  logic [SIZE_VMEM-1:0] threshold_i,
  input  logic [SIZE_VMEM-1:0] leak_i,
  output logic                 spike_o,
  output logic [SIZE_VMEM-1:0] vmem_o
);

  localparam int RW =
    (REFRACTORY > 0) ? $clog2(REFRACTORY + 1) : 1;

  logic signed [SIZE_VMEM-1:0] vmem_q, vmem_d;
  logic        [RW-1:0]        ref_q, ref_d;
  logic                        spike_q, spike_d;
  logic signed [SIZE_VMEM-1:0] thr;
  logic signed [SIZE_VMEM-1:0] v_acc;
  logic signed [SIZE_VMEM-1:0] v_leak;
  logic signed [SIZE_VMEM-1:0] v_sub;

  assign thr = $signed(threshold_i);

  assign v_acc = SIZE_VMEM'(sat_add(
    32'(vmem_q), 32'($signed(weight_i)), SIZE_VMEM));

  assign v_leak = SIZE_VMEM'(sat_add(
    32'(vmem_q), -(32'(leak_i)), SIZE_VMEM));

  assign v_sub = SIZE_VMEM'(sat_add(
    32'(v_leak), -(32'(thr)), SIZE_VMEM));

  always_comb begin
    vmem_d  = vmem_q;
    ref_d   = ref_q;
    spike_d = spike_q;
    unique case (1'b1)
      clr_i: begin
        vmem_d  = '0;
        ref_d   = '0;
        spike_d = 1'b0;
      end
      load_i: vmem_d = $signed(vmem_init_i);
      acc_i:  vmem_d = v_acc;
      fire_i: begin
        if (ref_q != '0) begin
          spike_d = 1'b0;
          ref_d   = ref_q - RW'(1);
          vmem_d  = v_leak;
        end else if (v_leak >= thr) begin
          spike_d = 1'b1;
          ref_d   = RW'(REFRACTORY);
          vmem_d  = (RESET_MODE != 0) ? v_sub : '0;
        end else begin
          spike_d = 1'b0;
          vmem_d  = v_leak;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vmem_q  <= '0;
      ref_q   <= '0;
      spike_q <= 1'b0;
    end else begin
      vmem_q  <= vmem_d;
      ref_q   <= ref_d;
      spike_q <= spike_d;
    end
  end

  assign spike_o = spike_q;
  assign vmem_o  = vmem_q;

endmodule

// File: rtl/neuron_tile_lif.sv
// Tile of SIZE_TILE LIF neurons sequenced by the control-message
// FSM; owns the beat counter and the spike-valid pulse.
module neuron_tile_lif
  import neuron_pkg::*;
#(
  parameter int SIZE_CONTROL  = 4,
  parameter int SIZE_DATA     = 8,
  parameter int SIZE_VMEM     = 16,
  parameter int SIZE_TILE     = 4,
  parameter int NUM_INPUT     = 31,
  parameter int SIZE_COUNTERS = $clog2(NUM_INPUT + 1),
  parameter int REFRACTORY    = 2,
  parameter int RESET_MODE    = 0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [SIZE_CONTROL-1:0]        msgControl,
  input  logic [SIZE_DATA*SIZE_TILE-1:0] msgData,
  input  logic                           dataValid,
  input  logic [SIZE_VMEM*SIZE_TILE-1:0] msgVmem,
  input  logic [SIZE_VMEM-1:0]           threshold,
  input  logic [SIZE_VMEM-1:0]           leak,
  output logic [SIZE_TILE-1:0]           spikeBuffer,
  output logic                           spikeValid,
  output logic [SIZE_VMEM*SIZE_TILE-1:0] vmemOut,
  output logic [2:0]                     stateOut,
  output logic [SIZE_COUNTERS-1:0]       inputCount
);

  state_e                   state_q;
  logic [SIZE_COUNTERS-1:0] cnt_q;
  logic                     valid_q;

  logic is_rst, is_setup, is_data, is_stop, is_fin;
  logic beat, last_beat;

  assign is_rst   = msgControl == SIZE_CONTROL'(CTRL_RESET);
  assign is_setup = msgControl == SIZE_CONTROL'(CTRL_SETUP);
  assign is_data  = msgControl == SIZE_CONTROL'(CTRL_DATA);
  assign is_stop  = msgControl == SIZE_CONTROL'(CTRL_STOP);
  assign is_fin   = msgControl == SIZE_CONTROL'(CTRL_FINISHED);

  assign beat = (state_q == ST_ACCUM) && dataValid
    && (cnt_q < SIZE_COUNTERS'(NUM_INPUT));
  assign last_beat = beat
    && (cnt_q == SIZE_COUNTERS'(NUM_INPUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else if (is_rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= (state_q == ST_FIRE);
      case (state_q)
        ST_IDLE: if (is_setup) state_q <= ST_SETUP;
        ST_SETUP: begin
          cnt_q <= '0;
          if (is_data) state_q <= ST_ACCUM;
        end
        ST_ACCUM: begin
          if (beat) cnt_q <= cnt_q + 1'b1;
          // The beat lands before any transition on the same edge.
          if (last_beat || is_fin) begin
            state_q <= ST_FIRE;
          end else if (is_stop) begin
            state_q <= ST_PAUSE;
          end
        end
        ST_PAUSE: begin
          if (is_fin) begin
            state_q <= ST_FIRE;
          end else if (is_data) begin
            state_q <= ST_ACCUM;
          end
        end
        ST_FIRE: state_q <= ST_DONE;
        ST_DONE: if (is_setup) state_q <= ST_SETUP;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  logic do_load, do_acc, do_fire;

  assign do_load = !is_rst && (state_q == ST_SETUP);
  assign do_acc  = !is_rst && beat;
  assign do_fire = !is_rst && (state_q == ST_FIRE);

  for (genvar i = 0; i < SIZE_TILE; i++) begin : g_neuron
    neuron_lif_unit #(
      .SIZE_DATA  (SIZE_DATA),
      .SIZE_VMEM  (SIZE_VMEM),
      .REFRACTORY (REFRACTORY),
      .RESET_MODE (RESET_MODE)
    ) u_unit (
      .clk         (clk),
      .rst_n       (rst_n),
      .clr_i       (is_rst),
      .load_i      (do_load),
      .acc_i       (do_acc),
      .fire_i      (do_fire),
      .vmem_init_i (msgVmem[i*SIZE_VMEM +: SIZE_VMEM]),
      .weight_i    (msgData[i*SIZE_DATA +: SIZE_DATA]),
      .threshold_i (threshold),
      .leak_i      (leak),
      .spike_o     (spikeBuffer[i]),
      .vmem_o      (vmemOut[i*SIZE_VMEM +: SIZE_VMEM])
    );
  end

  assign spikeValid = valid_q;
  assign stateOut   = state_q;
  assign inputCount = cnt_q;

endmodule

// File: tb/tb_neuron_tile_lif.sv
// Directed bench for neuron_tile_lif; a second instance runs
// with subtractive reset so both reset modes see the same stimulus.
module tb_neuron_tile_lif;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  ctrl;
  logic [31:0] data;
  logic        dv;
  logic [63:0] vin;
  logic [15:0] thr;
  logic [15:0] lk;

  logic [3:0]  spk0, spk1;
  logic        sv0, sv1;
  logic [63:0] vo0, vo1;
  logic [2:0]  st0, st1;
  logic [4:0]  ic0, ic1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  neuron_tile_lif u_dut0 (
    .clk(clk), .rst_n(rst_n), .msgControl(ctrl),
    .msgData(data), .dataValid(dv), .msgVmem(vin),
    .threshold(thr), .leak(lk), .spikeBuffer(spk0),
    .spikeValid(sv0), .vmemOut(vo0), .stateOut(st0),
    .inputCount(ic0)
  );

  neuron_tile_lif #(.RESET_MODE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .msgControl(ctrl),
    .msgData(data), .dataValid(dv), .msgVmem(vin),
    .threshold(thr), .leak(lk), .spikeBuffer(spk1),
    .spikeValid(sv1), .vmemOut(vo1), .stateOut(st1),
    .inputCount(ic1)
  );

  task automatic check(
    input string              tag,
    input logic signed [31:0] got,
    input logic signed [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic signed [31:0] lane(
    input logic [63:0] v, input int i);
    logic signed [15:0] t;
    t = v[i*16 +: 16];
    return t;
  endfunction

  task automatic start(input logic [63:0] v);
    ctrl = 4'b0010;
    vin  = v;
    dv   = 1'b0;
    step();
    ctrl = 4'b0110;
    step();
  endtask

  initial begin
    ctrl = 4'b0000;
    data = '0;
    dv   = 1'b0;
    vin  = '0;
    thr  = 16'd40;
    lk   = 16'd2;
    step(2);
    check("rst_state", st0, 0);
    check("rst_vmem", vo0, 0);
    check("rst_spk", spk0, 0);
    check("rst_cnt", ic0, 0);
    check("rst_valid", sv0, 0);
    rst_n = 1'b1;
    step();

    // accumulate 10 beats of 5
    ctrl = 4'b0010;
    step();
    check("setup_state", st0, 1);
    ctrl = 4'b0110;
    step();
    check("accum_state", st0, 2);
    data = {4{8'd5}};
    dv   = 1'b1;
    step(10);
    dv   = 1'b0;
    check("acc_cnt", ic0, 10);
    check("acc_v0", lane(vo0, 0), 50);
    check("acc_v3", lane(vo0, 3), 50);

    // fire: 50-2=48 >= 40 (timestep t)
    ctrl = 4'b1000;
    step();
    check("fire_state", st0, 4);
    check("fire_nvalid", sv0, 0);
    step();
    check("done_state", st0, 5);
    check("fire_valid", sv0, 1);
    check("fire_spk", spk0, 4'hf);
    check("fire_m0_v", lane(vo0, 2), 0);
    check("fire_m1_v", lane(vo1, 2), 8);
    check("fire_m1_spk", spk1, 4'hf);
    step();
    check("valid_pulse", sv0, 0);
    check("spk_hold", spk0, 4'hf);

    // saturation (timestep t+1, refractory)
    start({16'd0, 16'd0, 16'hFFFF - 16'd32759, 16'd32760});
    check("sat_load", lane(vo0, 0), 32760);
    data = {8'd0, 8'd1, 8'h80, 8'h7f};
    dv   = 1'b1;
    step(2);
    dv   = 1'b0;
    check("sat_hi", lane(vo0, 0), 32767);
    check("sat_lo", lane(vo0, 1), -32768);
    check("sat_l2", lane(vo0, 2), 2);
    ctrl = 4'b1000;
    step(2);
    check("ref1_spk", spk0, 0);
    check("ref1_valid", sv0, 1);
    check("leak_hi", lane(vo0, 0), 32765);
    check("leak_lo", lane(vo0, 1), -32768);
    check("leak_neg", lane(vo0, 3), -2);
    check("ref1_m1_spk", spk1, 0);

    // auto-fire with pause (timestep t+2, refractory)
    start({4{16'd100}});
    data = {4{8'd1}};
    dv   = 1'b1;
    step(10);
    check("af_cnt10", ic0, 10);
    ctrl = 4'b0000;
    step();
    check("pause_state", st0, 3);
    check("pause_cnt", ic0, 11);
    step();
    check("pause_drop", ic0, 11);
    check("pause_vmem", lane(vo0, 0), 111);
    ctrl = 4'b0110;
    step();
    check("resume_state", st0, 2);
    check("resume_cnt", ic0, 11);
    step(19);
    check("af_cnt30", ic0, 30);
    check("af_state30", st0, 2);
    step();
    check("af_fire", st0, 4);
    check("af_cnt31", ic0, 31);
    check("af_v131", lane(vo0, 1), 131);
    step();
    dv = 1'b0;
    check("af_done", st0, 5);
    check("af_drop", ic0, 31);
    check("af_leak", lane(vo0, 1), 129);
    check("ref2_spk", spk0, 0);

    // timestep t+3: refractory over
    start({4{16'd100}});
    dv = 1'b1;
    step();
    dv   = 1'b0;
    ctrl = 4'b1000;
    step(2);
    check("ref3_spk", spk0, 4'hf);
    check("ref3_m0_v", lane(vo0, 0), 0);
    check("ref3_m1_v", lane(vo1, 0), 59);

    // asynchronous reset mid-ACCUM
    start({4{16'd100}});
    dv = 1'b1;
    step();
    dv = 1'b0;
    check("pre_rst_cnt", ic0, 1);
    check("pre_rst_v", lane(vo0, 0), 101);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_state", st0, 0);
    check("arst_vmem", vo0, 0);
    check("arst_spk", spk0, 0);
    check("arst_cnt", ic0, 0);
    step();
    rst_n = 1'b1;
    ctrl  = 4'b0000;
    step();

    // refractory cleared by reset: spike at once
    start({4{16'd100}});
    dv = 1'b1;
    step();
    dv   = 1'b0;
    ctrl = 4'b1000;
    step(2);
    check("post_rst_spk", spk0, 4'hf);

    // RESET code mid-ACCUM
    start({4{16'd100}});
    dv = 1'b1;
    step();
    check("pre_code_cnt", ic0, 1);
    ctrl = 4'b0001;
    step();
    dv = 1'b0;
    check("code_state", st0, 0);
    check("code_vmem", vo0, 0);
    check("code_spk", spk0, 0);
    check("code_cnt", ic0, 0);
    check("code_m1_vmem", vo1, 0);
    ctrl = 4'b0000;
    step();
    check("idle_hold", st0, 0);

    $display("Simulation finished: %0d checks, %0d errors",
      checks, errors);
    $finish;
  end

endmodule
